// File: rtl/l1d_cache.sv
// l1d_cache: direct-mapped write-through L1 data cache; define L1D_CACHE_EN to build the tag/data RAM (undefined: every access goes to the bus)
module l1d_cache #(
  parameter int LINES  = 128,
  parameter int ADDR_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_data,
  output logic [31:0]       cpu_q,
  output logic              cpu_busy,
  input  logic              hold,
  input  logic              flush,
  output logic [ADDR_W-1:0] bus_l1d_addr,
  output logic              bus_l1d_start,
  output logic [31:0]       bus_l1d_data,
  output logic              bus_l1d_we,
  input  logic [31:0]       bus_l1d_q,
  input  logic              bus_l1d_done,
  input  logic              bus_l1d_ready
);
  typedef enum logic [2:0] {IDLE, LOOKUP, BUS_REQ, BUS_WAIT, DONE, FLUSH} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, cpu_q_q, cpu_q_d;
  logic              we_q, we_d;
  logic              req, hit, flush_end;
  logic [31:0]       hit_data;
  logic              unused_ok;
  assign req          = cpu_re | cpu_we;
  assign unused_ok    = ^cpu_addr[31:ADDR_W];
  assign cpu_q        = cpu_q_q;
  assign bus_l1d_addr = addr_q;
  assign bus_l1d_data = data_q;
  assign bus_l1d_we   = we_q;
`ifdef L1D_CACHE_EN
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int LW    = 1 + TAG_W + 32;
  localparam state_t RST_STATE = FLUSH;
  logic [LW-1:0]    mem [LINES];
  logic [LW-1:0]    rd_q, mem_w;
  logic [IDX_W-1:0] cnt_q, cnt_d, mem_a;
  logic             mem_we;
  assign hit       = rd_q[LW-1] && rd_q[LW-2 -: TAG_W] == addr_q[ADDR_W-1 -: TAG_W];
  assign hit_data  = rd_q[31:0];
  assign flush_end = cnt_q == IDX_W'(LINES - 1);
  // single RAM write port shared by the invalidation sweep, write-hit update and read-miss fill
  always_comb begin
    cnt_d  = state_q == FLUSH ? cnt_q + IDX_W'(1) : cnt_q;
    mem_a  = state_q == FLUSH ? cnt_q : addr_q[IDX_W-1:0];
    mem_w  = state_q == FLUSH ? '0 : {1'b1, addr_q[ADDR_W-1 -: TAG_W], we_q ? data_q : bus_l1d_q};
    mem_we = !reset && (state_q == FLUSH || (state_q == LOOKUP && we_q && hit) ||
                        (state_q == BUS_WAIT && bus_l1d_done && !we_q));
  end
  // line RAM; the read is issued from the incoming address while idle so LOOKUP sees it registered
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_w;
    if (state_q == IDLE) rd_q <= mem[cpu_addr[IDX_W-1:0]];
  end
  // sweep index wraps back to zero at the end of every sweep
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
`else
  localparam state_t RST_STATE = IDLE;
  assign hit       = 1'b0;
  assign hit_data  = '0;
  assign flush_end = 1'b1;
`endif
  // next-state, request latching and CPU/bus handshake
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_d          = we_q;
    cpu_q_d       = cpu_q_q;
    cpu_busy      = 1'b0;
    bus_l1d_start = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_busy = req & !hold;
        if (flush) state_d = FLUSH;
        else if (req && !hold) begin
          addr_d  = cpu_addr[ADDR_W-1:0];
          data_d  = cpu_data;
          we_d    = cpu_we;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cpu_busy = 1'b1;
        cpu_q_d  = !we_q && hit ? hit_data : cpu_q_q;
        state_d  = !we_q && hit ? DONE : BUS_REQ;
      end
      BUS_REQ: begin
        cpu_busy      = 1'b1;
        bus_l1d_start = bus_l1d_ready & !reset;
        state_d       = bus_l1d_ready ? BUS_WAIT : BUS_REQ;
      end
      BUS_WAIT: begin
        cpu_busy = 1'b1;
        cpu_q_d  = bus_l1d_done && !we_q ? bus_l1d_q : cpu_q_q;
        state_d  = bus_l1d_done ? DONE : BUS_WAIT;
      end
      DONE: state_d = IDLE;
      FLUSH: begin
        cpu_busy = 1'b1;
        state_d  = flush_end ? IDLE : FLUSH;
      end
      default: state_d = RST_STATE;
    endcase
  end
  // state and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      cpu_q_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cpu_q_q <= cpu_q_d;
    end
  end
endmodule

// File: tb/tb_l1d_cache.sv
// tb_l1d_cache: randomized check of l1d_cache against a line-level cache and bus memory model
module tb_l1d_cache;
`ifdef L1D_CACHE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] cpu_addr, cpu_data, cpu_q, bus_l1d_data, bus_l1d_q;
  logic        cpu_re, cpu_we, cpu_busy, hold, flush;
  logic [26:0] bus_l1d_addr;
  logic        bus_l1d_start, bus_l1d_we, bus_l1d_done, bus_l1d_ready = 1'b1;
  int          vectors = 0, miscompares = 0;
  int          starts = 0, unstable = 0, bad_start = 0, lat = 2, ready_mode = 0;
  logic [26:0] last_addr;
  logic        last_we;
  logic [31:0] last_data;
  bit          mv [128];
  logic [19:0] mt [128];
  logic [31:0] md [128];
  logic [31:0] bmem [logic [26:0]];

  l1d_cache dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_data(cpu_data), .cpu_q(cpu_q), .cpu_busy(cpu_busy), .hold(hold), .flush(flush),
    .bus_l1d_addr(bus_l1d_addr), .bus_l1d_start(bus_l1d_start), .bus_l1d_data(bus_l1d_data),
    .bus_l1d_we(bus_l1d_we), .bus_l1d_q(bus_l1d_q), .bus_l1d_done(bus_l1d_done),
    .bus_l1d_ready(bus_l1d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [26:0] a);
    return bmem.exists(a) ? bmem[a] : (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    bus_l1d_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  always @(negedge clk) if (bus_l1d_start && (!bus_l1d_ready || reset)) bad_start++;

  initial begin
    logic [26:0] ba;
    logic        bw, ab;
    logic [31:0] bd;
    bus_l1d_done = 1'b0;
    bus_l1d_q    = '0;
    forever begin
      @(negedge clk);
      if (bus_l1d_start) begin
        starts++;
        ba = bus_l1d_addr; bw = bus_l1d_we; bd = bus_l1d_data; ab = 1'b0;
        last_addr = ba; last_we = bw; last_data = bd;
        repeat (lat) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
          if (!ab && (bus_l1d_addr !== ba || bus_l1d_we !== bw || bus_l1d_data !== bd || bus_l1d_start)) unstable++;
        end
        bus_l1d_q = bw ? $urandom : mem_rd(ba);
        if (bw && !ab) bmem[ba] = bd;
        bus_l1d_done = 1'b1;
        @(negedge clk);
        bus_l1d_done = 1'b0;
        bus_l1d_q    = $urandom;
      end
    end
  end

  task automatic wait_idle(output int bc);
    bc = 0;
    #1;
    while (cpu_busy && bc < 1000) begin
      bc++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input int hc,
                        output int bc, output logic [31:0] q);
    @(negedge clk);
    cpu_addr = a; cpu_data = d; cpu_we = w; cpu_re = !w || ($urandom_range(0, 1) == 1);
    hold = hc > 0;
    for (int k = 0; k < hc; k++) begin
      #1 chk("hold_busy", 32'(cpu_busy), 0);
      @(negedge clk);
    end
    hold = 1'b0;
    bc = 0;
    #1;
    while (cpu_busy && bc < 500) begin
      bc++;
      @(negedge clk);
      if (bc == 1) hold = $urandom_range(0, 1) == 1;
      #1;
    end
    if (cpu_busy) chk("busy_timeout", 32'(cpu_busy), 0);
    q = cpu_q;
    cpu_re = 1'b0; cpu_we = 1'b0; hold = 1'b0;
  endtask

  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d, input int hc, output int bc);
    logic [26:0] wa = a[26:0];
    int          i  = int'(wa[6:0]);
    bit          hit = EN && mv[i] && mt[i] == wa[26:7];
    logic [31:0] exp_q = hit ? md[i] : mem_rd(wa);
    int          s0 = starts;
    logic [31:0] q;
    access(w, a, d, hc, bc, q);
    chk("starts", 32'(starts - s0), (hit && !w) ? 0 : 1);
    if (!w) chk("rdata", q, exp_q);
    if (hit && !w) chk("hit_lat", 32'(bc), 2);
    else begin
      chk("bus_addr", 32'(last_addr), 32'(wa));
      chk("bus_we", 32'(last_we), 32'(w));
      if (w) chk("bus_data", last_data, d);
    end
    if (!w && !hit) begin mv[i] = 1'b1; mt[i] = wa[26:7]; md[i] = exp_q; end
    if (w && hit) md[i] = d;
  endtask

  task automatic do_flush();
    int bc;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(bc);
    chk("flush_len", 32'(bc), EN ? 128 : 1);
    mv = '{default: 1'b0};
  endtask

  initial begin
    int          bc, s0;
    logic [31:0] a;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_data = '0; hold = 1'b0; flush = 1'b0;
    mv = '{default: 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_q", cpu_q, 0);
    chk("rst_start", 32'(bus_l1d_start), 0);
    chk("rst_baddr", 32'(bus_l1d_addr), 0);
    chk("rst_bwe", 32'(bus_l1d_we), 0);
    chk("rst_bdata", bus_l1d_data, 0);
    reset = 1'b0;
    wait_idle(bc);
    chk("sweep_len", 32'(bc), EN ? 128 : 0);
    chk("sweep_starts", 32'(starts), 0);
    bmem[27'h40] = 32'hDEADBEEF;
    lat = 5;
    run(1'b0, 32'h40, 0, 0, bc);
    run(1'b0, 32'h40, 0, 0, bc);
    run(1'b1, 32'h40, 32'h12345678, 0, bc);
    run(1'b0, 32'h40, 0, 0, bc);
    run(1'b0, 32'h2040, 0, 3, bc);
    run(1'b0, 32'h40, 0, 0, bc);
    lat = 2;
    ready_mode = 2;
    fork
      run(1'b0, 32'h2040, 0, 0, bc);
      begin repeat (12) @(negedge clk); ready_mode = 0; end
    join
    chk("ready_stall", 32'(bc >= 10), 1);
    do_flush();
    run(1'b0, 32'h40, 0, 0, bc);
    lat = 3;
    s0 = starts;
    @(negedge clk);
    cpu_addr = 32'h40; cpu_re = 1'b1;
    for (int k = 0; k < 50 && starts == s0; k++) begin @(negedge clk); #2; end
    @(negedge clk);
    reset = 1'b1; cpu_re = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_idle(bc);
    chk("rst_sweep_len", 32'(bc), EN ? 128 : 0);
    chk("rst_starts", 32'(starts - s0), 1);
    chk("rst_q_mid", cpu_q, 0);
    mv = '{default: 1'b0};
    repeat (4) @(negedge clk);
    run(1'b0, 32'h40, 0, 0, bc);
    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(1, 6);
      ready_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) do_flush();
      a = ($urandom & 32'hF800_0000) | (32'($urandom_range(0, 3)) << 13) | 32'($urandom_range(0, 15));
      run($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0, bc);
    end
    ready_mode = 0;
    repeat (4) @(negedge clk);
    chk("bus_stable", 32'(unstable), 0);
    chk("start_gating", 32'(bad_start), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/l1d_cache.md
L1D_CACHE -- requirements
Module: l1d_cache

Interface
REQ-001 SHALL have parameter LINES, default 128, number of direct-mapped one-word lines (power of two).
REQ-002 SHALL have parameter ADDR_W, default 27, bus word-address width; tag width = ADDR_W - log2(LINES), 20 at defaults.
REQ-003 SHALL have ports (clock and reset first):
 clk  in  1  single clock, rising edge; one clock domain, all logic on clk.
 reset  in  1  reset, synchronous, active-high.
 cpu_addr  in  32  word address; [ADDR_W-1:0] used, upper bits ignored.
 cpu_re  in  1  read request.
 cpu_we  in  1  write request; wins over cpu_re when both high.
 cpu_data  in  32  write data.
 cpu_q  out  32  read data, valid in DONE only.
 cpu_busy  out  1  stall request to CPU pipeline.
 hold  in  1  blocks acceptance of new requests.
 flush  in  1  invalidate all lines.
 bus_l1d_addr  out  ADDR_W  bus word address.
 bus_l1d_start  out  1  one-cycle bus request strobe.
 bus_l1d_data  out  32  bus write data.
 bus_l1d_we  out  1  bus write enable.
 bus_l1d_q  in  32  bus read data, valid with bus_l1d_done.
 bus_l1d_done  in  1  one-cycle completion pulse.
 bus_l1d_ready  in  1  bus can accept start.

Function
REQ-004 SHALL be write-through, no-write-allocate; each line holds valid, tag and 32-bit data in synchronous-read RAM.
REQ-005 SHALL have states IDLE, LOOKUP, BUS_REQ, BUS_WAIT, DONE, FLUSH.
REQ-006 IDLE: if flush -> FLUSH; else if (cpu_re|cpu_we) & !hold -> latch addr/data/we, issue tag read, -> LOOKUP; flush has priority over a request in the same cycle.
REQ-007 cpu_busy SHALL be high combinationally in the accepting IDLE cycle and in LOOKUP, BUS_REQ, BUS_WAIT and FLUSH; low in DONE and in non-accepting IDLE cycles.
REQ-008 LOOKUP read hit (valid and tag match): cpu_q <= line data, -> DONE; read hit latency 2 cycles (busy in cycles N and N+1, result in N+2).
REQ-009 LOOKUP read miss -> BUS_REQ with bus_l1d_we=0; LOOKUP write: hit -> update line data; miss -> line unchanged; either way -> BUS_REQ with bus_l1d_we=1.
REQ-010 BUS_REQ: assert bus_l1d_start for exactly one cycle once bus_l1d_ready=1, -> BUS_WAIT; while ready=0, wait with start low.
REQ-011 bus_l1d_addr, bus_l1d_we and bus_l1d_data SHALL be stable from the start cycle until done; bus_l1d_start SHALL never be high outside BUS_REQ.
REQ-012 BUS_WAIT on bus_l1d_done: read -> write line {valid=1, tag, bus_l1d_q}, cpu_q <= bus_l1d_q; write -> nothing further; -> DONE.
REQ-013 DONE: exactly one cycle, busy low, no request accepted, -> IDLE; CPU request held during the stall is not re-executed.
REQ-014 FLUSH: clear valid of index 0..LINES-1, one per cycle, then -> IDLE; LINES cycles total; flush is ignored outside IDLE.
REQ-015 bus_l1d_done outside BUS_WAIT SHALL be ignored.
REQ-016 hold SHALL not affect a transaction already accepted.

Reset
REQ-017 reset SHALL set state FLUSH, index counter 0, bus_l1d_start 0, bus_l1d_we 0, bus_l1d_addr 0, bus_l1d_data 0, cpu_q 0; reset overrides all other inputs.
REQ-018 Reset mid-transaction SHALL abandon it; a late bus_l1d_done SHALL be ignored; no line written.
REQ-019 cpu_busy SHALL remain high for LINES cycles after reset deasserts (invalidation sweep).

Configuration
REQ-020 Macro L1D_CACHE_EN defined: behaviour as above.
REQ-021 Macro L1D_CACHE_EN undefined: no tag/data RAM; LOOKUP always treated as miss, every access goes to bus; FLUSH lasts 1 cycle; reset goes to IDLE; ports unchanged.

Verification
REQ-022 Post-reset: busy high 128 cycles, bus_l1d_start never high -> then IDLE, busy low.
REQ-023 Read 0x00000040, bus returns 0xDEADBEEF after 5 cycles -> one start, bus_l1d_addr 0x40, cpu_q 0xDEADBEEF in DONE; repeat read -> no start, result cycle N+2.
REQ-024 Write 0x12345678 to cached 0x40 -> bus write addr 0x40 data 0x12345678; subsequent read hits returning 0x12345678.
REQ-025 Read 0x40 then 0x2040 (same index, tag differs) -> both miss; read 0x40 again -> miss.
REQ-026 bus_l1d_ready low 10 cycles during miss -> start delayed until ready, busy high throughout; flush then read 0x40 -> miss.
REQ-027 reset asserted in BUS_WAIT, done arrives 2 cycles later -> ignored, FLUSH sweep runs, later read 0x40 misses.
